// File: rtl/stack_pkg.sv
// stack_pkg: shared defaults and command decode for the operand stack.
//   STACK_WIDTH / STACK_DEPTH : default word width and entry count
//   stack_op_e                : decoded command
//   decode_op(push,pop,tos)   : priority decode; replace > push > pop > tos
package stack_pkg;
    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_TOS,
        OP_REPLACE
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop, input logic tos);
        return (push && pop) ? OP_REPLACE :
               push          ? OP_PUSH    :
               pop           ? OP_POP     :
               tos           ? OP_TOS     : OP_NONE;
    endfunction
endpackage

// File: rtl/stack_mem.sv
// stack_mem: 1-write/1-read register array, synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/stack_unit.sv
// stack_unit: bounded operand stack with registered read port and sticky error flags.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   push/pop/tos : command strobes, level-sampled every edge
//   din        : data to push
//   dout       : registered read data, held when not updated
//   dout_valid : dout was updated by the previous edge
//   count      : stored entries 0..DEPTH; empty/full derived from it
//   overflow   : sticky, push while full
//   underflow  : sticky, pop/tos/replace while empty
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [PW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = PW - 1;

    stack_op_e        op;
    logic [PW-1:0]    sp, sp_m1;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] top;
    logic             we, rd, inc, dec, reads;

    assign count = sp;
    assign empty = sp == '0;
    assign full  = sp == PW'(DEPTH);

    always_comb begin
        op    = decode_op(push, pop, tos);
        sp_m1 = sp - PW'(1);
        reads = op == OP_POP || op == OP_TOS || op == OP_REPLACE;
        rd    = reads && !empty;
        // replace on an empty stack degenerates into a plain push
        inc   = (op == OP_PUSH && !full) || (op == OP_REPLACE && empty);
        dec   = op == OP_POP && !empty;
        we    = op == OP_REPLACE || (op == OP_PUSH && !full);
        waddr = AW'((op == OP_REPLACE && !empty) ? sp_m1 : sp);
    end

    // read of the old top happens before the replace write lands
    stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (AW'(sp_m1)),
        .rdata (top)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sp         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= rd;
            if (rd) dout <= top;
            if (inc) sp <= sp + PW'(1);
            else if (dec) sp <= sp_m1;
            if (op == OP_PUSH && full) overflow <= 1'b1;
            if (reads && empty) underflow <= 1'b1;
        end
endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the multicycle stack-machine datapath. It executes the `push`, `pop` and `tos` strobes issued by the controller: it stores values from the datapath's `st_data` path and returns the top-of-stack value to the `A` register / ALU operand path. It replaces the ad-hoc stack registers inside the datapath with a single bounded unit. That unit reports status, so the controller can detect overflow and underflow.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `DEPTH`, 16: number of entries. Must be a power of two, at least 2.
- `PW`, $clog2(DEPTH)+1: width of the count/pointer.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `push`  in  1  write `din` onto the stack.
- `pop`  in  1  remove the top entry and present it on `dout`.
- `tos`  in  1  present the top entry on `dout` without removing it.
- `din`  in  WIDTH  data to push.
- `dout`  out  WIDTH  registered read data.
- `dout_valid`  out  1  one-cycle pulse; `dout` was updated by the previous edge.
- `count`  out  PW  current number of stored entries, 0..DEPTH.
- `empty`  out  1  asserted when `count==0`.
- `full`  out  1  asserted when `count==DEPTH`.
- `overflow`  out  1  sticky error flag: push attempted while full.
- `underflow`  out  1  sticky error flag: pop or tos attempted while empty.

## Operation
- Storage is `DEPTH` words. Stack pointer `sp` equals `count`; the top entry is `mem[sp-1]`.
- Command decode each cycle, in priority order:
  - **push & pop**: replace. `dout <= mem[sp-1]`, then `mem[sp-1] <= din`; `sp` is unchanged; `dout_valid` pulses. If empty, this is a plain push, `underflow` sets, and `dout_valid` stays low.
  - **push only**: if not full, `mem[sp] <= din` and `sp++`. If full, there is no write, `sp` is held, and `overflow` sets.
  - **pop only**: if not empty, `dout <= mem[sp-1]`, `sp--`, and `dout_valid` pulses. If empty, `sp` is held, `dout` is held, and `underflow` sets.
  - **tos only**: if not empty, `dout <= mem[sp-1]` and `dout_valid` pulses; otherwise `underflow` sets.
  - `tos` combined with `push` and/or `pop` is ignored; the push/pop rules apply.
- `overflow` and `underflow` clear only on reset.
- `empty`, `full` and `count` are driven combinationally from `sp` registers.
- `dout` holds its last value when not updated.

## Timing
- Reset (asynchronous, `rst==0`):
  - `sp=0`, `dout=0`, `dout_valid=0`, `overflow=0`, `underflow=0`.
  - Hence `empty=1`, `full=0`, `count=0`.
  - Memory contents are not reset and are undefined.
- Reset asserted mid-operation discards any in-flight command. State returns to the reset values immediately, with no edge required.
- Read latency is 1 cycle: a command sampled at edge N gives `dout`/`dout_valid` valid after edge N and through to edge N+1.
- A push at edge N is readable by a `tos` at edge N+1 (write-before-read across cycles). No bypass is needed within a cycle because replace reads the old value by definition.
- Strobes are level-sampled every edge. The controller must assert each strobe for exactly one cycle per operation; a strobe held for k cycles performs k operations.
- Pointer arithmetic is PW bits wide and never wraps: it saturates at 0 and at DEPTH through the guards above.

## Structure
- Package `stack_pkg`:
  - default `WIDTH` and `DEPTH` constants.
  - enum `stack_op_e` = {`OP_NONE`, `OP_PUSH`, `OP_POP`, `OP_TOS`, `OP_REPLACE`}, produced by a priority decode function `decode_op(push,pop,tos)`.
- Sub-module `stack_mem`: a 1-write/1-read synchronous-write, asynchronous-read register array, instantiated once.
- `stack_unit` holds `sp`, the flags, the `dout` register and the decode.

## Test plan
- **Reset:** drive `rst=0` mid-run after 3 pushes, then release → `count=0`, `empty=1`, `dout=0`, flags 0.
- **LIFO order:** push 0x11, 0x22, 0x33, then pop ×3 → `dout` = 0x33, 0x22, 0x11 on consecutive cycles, each with `dout_valid`; `empty=1` after the last pop.
- **Full boundary** (`DEPTH=16`): push 0x00..0x0F → `full=1`, `count=16`. A 17th push of 0xAA → `overflow=1`, `count=16`. A subsequent `tos` returns 0x0F.
- **Empty boundary:** pop with empty → `underflow=1`, `dout` unchanged, `dout_valid=0`. A `tos` with empty → same result.
- **Replace:** push 0x05, then `push`&`pop` with `din=0x09` → `dout=0x05`, `count=1`. A following `tos` → `dout=0x09`.
- **Priority:** with 2 entries (0x01, 0x02), assert `tos`&`pop` → `dout=0x02`, `count=1`. Then `tos`&`push` with `din=0x07` → `count=2`, `dout_valid=0`.
